fb_write_scheduler: RTL
=======================

// Module: fb_write_scheduler
// PURPOSE
//  Sits between N pixel producers (fragment shader lanes) and the framebuffer memory master port.
//  Round-robin arbitrates pixel writes, converts (x,y) to linear address, drops off-screen pixels.
//  Sequences full-screen clear fills on command; one registered write request toward the interconnect.
// PARAMETERS
//  SCREEN_WIDTH   640  pixels per row
//  SCREEN_HEIGHT  480  rows
//  COLOR_WIDTH    32   bits per pixel
//  N_PORTS        2    pixel requesters (>=1)
//  ADDR_W         $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)  (derived, localparam)
// PORTS
//  clk            in   1                 single clock; all logic rising-edge
//  rst            in   1                 asynchronous, active-high reset
//  i_px_valid     in   N_PORTS           per-port pixel valid
//  o_px_ready     out  N_PORTS           per-port accept; transfer = valid & ready
//  i_px_x         in   N_PORTS*10        packed x, port p at [p*10 +: 10]
//  i_px_y         in   N_PORTS*10        packed y, port p at [p*10 +: 10]
//  i_px_color     in   N_PORTS*COLOR_WIDTH  packed color
//  i_clear_start  in   1                 1-cycle pulse: start clear fill
//  i_clear_color  in   COLOR_WIDTH       fill color, sampled with i_clear_start
//  o_mem_req      out  1                 write request valid
//  o_mem_addr     out  ADDR_W            linear pixel address y*SCREEN_WIDTH+x
//  o_mem_wdata    out  COLOR_WIDTH       write data
//  i_mem_ack      in   1                 interconnect accepts request this cycle
//  o_busy         out  1                 state != IDLE or o_mem_req
//  o_clear_done   out  1                 1-cycle pulse when clear fully acked
//  o_drop_count   out  16                saturating count of off-screen pixels dropped
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; RR pointer = port N_PORTS-1 (port 0 first); clear counter 0.
//  Output slot: single register; o_mem_req/addr/wdata held stable until i_mem_ack.
//   slot_free = !o_mem_req | i_mem_ack; new request loads on slot_free; req cleared when acked and nothing loads.
//  States: IDLE -> CLEAR on i_clear_start (IDLE only; ignored in CLEAR/DRAIN).
//   CLEAR: each slot_free cycle load addr=cnt, data=latched clear color, cnt++; after loading
//    addr W*H-1 -> DRAIN. DRAIN: when last request acked (o_mem_req & i_mem_ack) -> IDLE, o_clear_done=1 that cycle's next edge (registered pulse, 1 cycle).
//  Pixel accept only in IDLE with no i_clear_start that cycle (clear wins simultaneous event).
//  Arbitration: among valid ports, grant first index after RR pointer (wrapping); at most one o_px_ready
//   high per cycle; ready[g] = grant & IDLE & !i_clear_start & slot_free. Ready is combinational on valid.
//  Pointer updates to granted port only on transfer; stalled grant not reissued to another port (no change without transfer).
//  Address: ADDR_W-bit y*SCREEN_WIDTH+x computed at full width, then truncated.
//  Bounds: x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT -> pixel accepted (ready high, slot need not be free),
//   no request generated, o_drop_count++ (saturates at 16'hFFFF); pointer still advances.
//  Latency: accepted in-bounds pixel drives o_mem_req on the following cycle.
//  Reset mid-clear/mid-request: request dropped, clear aborted, no o_clear_done pulse.
// TESTING
//  1 Assert rst async mid-cycle -> o_mem_req, o_px_ready, o_busy, o_drop_count all 0 immediately.
//  2 Port0 x=3,y=2 valid, ack held 1 -> next cycle o_mem_req=1, addr=1283, wdata=color; one cycle only.
//  3 Same pixel, ack=0 for 5 cycles -> req/addr/data stable 5 cycles; port ready=0 meanwhile; clear on ack.
//  4 Ports 0,1 valid continuously, ack=1 -> grants 0,1,0,1; addresses match each port's x,y.
//  5 Port0 x=640,y=0 -> ready=1, no o_mem_req, o_drop_count=1; y=480 -> count=2.
//  6 W=4,H=2, clear_start color=0xAABBCCDD, ack random -> addrs 0..7 in order, pixel ready=0 throughout,
//    second clear_start ignored, o_clear_done pulses once after addr 7 acked, then IDLE accepts pixels.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: round-robin pixel arbitration with off-screen drop,
// full-screen clear sequencing, and a single registered write request slot.
module fb_write_scheduler #(
  parameter  int SCREEN_WIDTH  = 640,
  parameter  int SCREEN_HEIGHT = 480,
  parameter  int COLOR_WIDTH   = 32,
  parameter  int N_PORTS       = 2,
  localparam int ADDR_W        = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS-1:0]             i_px_valid,
  output logic [N_PORTS-1:0]             o_px_ready,
  input  logic [N_PORTS*10-1:0]          i_px_x,
  input  logic [N_PORTS*10-1:0]          i_px_y,
  input  logic [N_PORTS*COLOR_WIDTH-1:0] i_px_color,
  input  logic                           i_clear_start,
  input  logic [COLOR_WIDTH-1:0]         i_clear_color,
  output logic                           o_mem_req,
  output logic [ADDR_W-1:0]              o_mem_addr,
  output logic [COLOR_WIDTH-1:0]         o_mem_wdata,
  input  logic                           i_mem_ack,
  output logic                           o_busy,
  output logic                           o_clear_done,
  output logic [15:0]                    o_drop_count
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int NPIX  = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic [COLOR_WIDTH-1:0] clr_color_q, clr_color_d;
  logic                   req_q, req_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [COLOR_WIDTH-1:0] data_q, data_d;
  logic [15:0]            drop_q, drop_d;
  logic                   done_q, done_d;

  logic                   grant_vld;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       cand;
  logic [9:0]             sel_x, sel_y;
  logic [COLOR_WIDTH-1:0] sel_color;
  logic [31:0]            lin_full;
  logic                   off_screen, slot_free, px_ok, xfer;

  // Search starts one past the last granted port, so port 0 wins first after reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N_PORTS);
      if (!grant_vld && i_px_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign sel_x      = i_px_x[grant_idx*10 +: 10];
  assign sel_y      = i_px_y[grant_idx*10 +: 10];
  assign sel_color  = i_px_color[grant_idx*COLOR_WIDTH +: COLOR_WIDTH];
  assign lin_full   = 32'(int'(sel_y) * SCREEN_WIDTH + int'(sel_x));
  assign off_screen = (int'(sel_x) >= SCREEN_WIDTH) || (int'(sel_y) >= SCREEN_HEIGHT);
  assign slot_free  = !req_q || i_mem_ack;

  // Off-screen pixels never occupy the slot, so they are taken even while it is full.
  assign px_ok = !rst && (state_q == S_IDLE) && !i_clear_start && grant_vld;
  assign xfer  = px_ok && (slot_free || off_screen);

  always_comb begin
    o_px_ready = '0;
    if (xfer) o_px_ready[grant_idx] = 1'b1;
  end

  // NOTE: every _d signal is given its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    clr_color_d = clr_color_q;
    req_d       = req_q && !i_mem_ack;
    addr_d      = addr_q;
    data_d      = data_q;
    drop_d      = drop_q;
    done_d      = 1'b0;

    if (xfer) begin
      ptr_d = grant_idx;
      if (off_screen) begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else begin
        req_d  = 1'b1;
        addr_d = lin_full[ADDR_W-1:0];
        data_d = sel_color;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_clear_start) begin
          state_d     = S_CLEAR;
          cnt_d       = '0;
          clr_color_d = i_clear_color;
        end
      end
      S_CLEAR: begin
        if (slot_free) begin
          req_d  = 1'b1;
          addr_d = cnt_q;
          data_d = clr_color_q;
          cnt_d  = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_ADDR) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (req_q && i_mem_ack) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_W'(N_PORTS - 1);
      cnt_q       <= '0;
      clr_color_q <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      drop_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      clr_color_q <= clr_color_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      drop_q      <= drop_d;
      done_q      <= done_d;
    end
  end

  assign o_mem_req    = req_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = data_q;
  assign o_busy       = (state_q != S_IDLE) || req_q;
  assign o_clear_done = done_q;
  assign o_drop_count = drop_q;

endmodule
